// File: rtl/reg_share_arbiter_if.sv
// Request/grant and shared-register bus between N_REQ producers and the arbiter.
// The master side is the producer/consumer group; the slave side is reg_share_arbiter.
interface reg_share_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       i_valid;
  logic [N_REQ*WIDTH-1:0] i_data;
  logic                   i_clear;
  logic [N_REQ-1:0]       o_ready;
  logic [WIDTH-1:0]       o_q;
  logic                   o_q_valid;
  logic [IDW-1:0]         o_owner;
  logic                   o_busy;

  modport master (
    output i_valid, i_data, i_clear,
    input  o_ready, o_q, o_q_valid, o_owner, o_busy
  );

  modport slave (
    input  i_valid, i_data, i_clear,
    output o_ready, o_q, o_q_valid, o_owner, o_busy
  );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit datapath among N_REQ requesters,
// with a programmable hold window after every load before the next grant.
module reg_share_arbiter #(
  parameter int WIDTH       = 8,
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input logic           i_clk,
  input logic           i_rst_n,
  reg_share_arbiter_if.slave bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic [CW-1:0]    hold_cnt;
  logic [IDW-1:0]   ptr;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [IDW-1:0]   owner;
  logic             busy;

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] grant_data;
  logic             found;
  logic [IDW-1:0]   next_ptr;

  // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    grant      = '0;
    grant_id   = '0;
    grant_data = '0;
    found      = 1'b0;
    if (state == IDLE && !bus.i_clear) begin
      for (int i = 0; i < N_REQ; i++) begin
        automatic int idx = (int'(ptr) + i) % N_REQ;
        if (!found && bus.i_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_id   = IDW'(idx);
          grant_data = bus.i_data[idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign next_ptr = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Reset leaves the FSM in IDLE, so the search result must be masked while reset is held.
  assign bus.o_ready   = i_rst_n ? grant : '0;
  assign bus.o_q       = q;
  assign bus.o_q_valid = q_valid;
  assign bus.o_owner   = owner;
  assign bus.o_busy    = busy;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      ptr      <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      owner    <= '0;
      busy     <= 1'b0;
    end else if (bus.i_clear) begin
      // Clear drops the data and the hold window but keeps fairness history (ptr, owner).
      state    <= IDLE;
      hold_cnt <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            q       <= grant_data;
            owner   <= grant_id;
            q_valid <= 1'b1;
            ptr     <= next_ptr;
            if (HOLD_CYCLES > 0) begin
              state    <= HOLD;
              hold_cnt <= CW'(HOLD_CYCLES);
              busy     <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == CW'(1)) begin
            state    <= IDLE;
            hold_cnt <= '0;
            busy     <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: two instances (hold window 2 and 0) run in lockstep against
// a cycle-level reference model built from the arbitration and hold-window rules.
module tb_reg_share_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_share_arbiter_if #(.WIDTH(8), .N_REQ(4)) ifa ();
  reg_share_arbiter_if #(.WIDTH(8), .N_REQ(4)) ifb ();

  reg_share_arbiter #(.WIDTH(8), .N_REQ(4), .HOLD_CYCLES(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
  reg_share_arbiter #(.WIDTH(8), .N_REQ(4), .HOLD_CYCLES(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

  int tests = 0;
  int fails = 0;

  // Stimulus and reference state, index 0 = dut_a, 1 = dut_b.
  int          hc[2] = '{2, 0};
  logic [3:0]  v[2];
  logic [31:0] dat[2];
  bit          clr[2];
  logic [7:0]  m_q[2];
  int          m_owner[2];
  int          m_ptr[2];
  int          m_wait[2];
  bit          m_qv[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    ifa.i_valid = v[0]; ifa.i_data = dat[0]; ifa.i_clear = clr[0];
    ifb.i_valid = v[1]; ifb.i_data = dat[1]; ifb.i_clear = clr[1];
  endtask

  function automatic int pick(input int d);
    if (m_wait[d] > 0 || clr[d]) return -1;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (m_ptr[d] + i) % 4;
      if (v[d][k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int d);
    int k;
    k = pick(d);
    return (k < 0) ? 4'b0000 : 4'(1 << k);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_q[d] = 8'h00; m_owner[d] = 0; m_ptr[d] = 0; m_wait[d] = 0; m_qv[d] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_q_a"},     32'(ifa.o_q),       32'(m_q[0]));
    check({tag, "_qv_a"},    32'(ifa.o_q_valid), 32'(m_qv[0]));
    check({tag, "_owner_a"}, 32'(ifa.o_owner),   32'(m_owner[0]));
    check({tag, "_busy_a"},  32'(ifa.o_busy),    32'(m_wait[0] > 0));
    check({tag, "_q_b"},     32'(ifb.o_q),       32'(m_q[1]));
    check({tag, "_qv_b"},    32'(ifb.o_q_valid), 32'(m_qv[1]));
    check({tag, "_owner_b"}, 32'(ifb.o_owner),   32'(m_owner[1]));
    check({tag, "_busy_b"},  32'(ifb.o_busy),    32'(m_wait[1] > 0));
  endtask

  // One clock: drive inputs, check grants, advance the model, check registered outputs.
  task automatic tick(input string tag);
    int k;
    drive();
    #1;
    check({tag, "_ready_a"}, 32'(ifa.o_ready), 32'(exp_ready(0)));
    check({tag, "_ready_b"}, 32'(ifb.o_ready), 32'(exp_ready(1)));
    for (int d = 0; d < 2; d++) begin
      k = pick(d);
      if (clr[d]) begin
        m_q[d] = 8'h00; m_qv[d] = 1'b0; m_wait[d] = 0;
      end else if (k >= 0) begin
        m_q[d]     = dat[d][k*8 +: 8];
        m_owner[d] = k;
        m_qv[d]    = 1'b1;
        m_ptr[d]   = (k + 1) % 4;
        m_wait[d]  = hc[d];
      end else begin
        m_qv[d] = 1'b0;
        if (m_wait[d] > 0) m_wait[d]--;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    v[0] = '0; v[1] = '0; clr[0] = 1'b0; clr[1] = 1'b0;
    for (int i = 0; i < n; i++) tick("idle");
  endtask

  // Asserts reset away from the clock edge and checks the asynchronous effect before any edge.
  task automatic apply_reset(input string tag);
    drive();
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_ready_a"}, 32'(ifa.o_ready), 32'h0);
    check({tag, "_ready_b"}, 32'(ifb.o_ready), 32'h0);
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    v[0] = '0; v[1] = '0; dat[0] = '0; dat[1] = '0; clr[0] = 1'b0; clr[1] = 1'b0;
    model_reset();
    drive();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_reset");

    // Reset in the middle of a hold window with 0x3C loaded.
    v[0] = 4'b0001; dat[0] = 32'h0000_003C;
    tick("load3c");
    check("load3c_q", 32'(ifa.o_q), 32'h3C);
    check("load3c_busy", 32'(ifa.o_busy), 32'h1);
    v[0] = 4'b1111; v[1] = 4'b1111;
    apply_reset("midhold_rst");
    tick("first_grant");
    check("first_grant_owner", 32'(ifa.o_owner), 32'h0);

    // Single request with a hold window of two.
    idle(3);
    v[0] = 4'b0100; dat[0] = 32'h00A5_0000;
    tick("single_T");
    check("single_q", 32'(ifa.o_q), 32'hA5);
    check("single_owner", 32'(ifa.o_owner), 32'h2);
    for (int i = 0; i < 2; i++) begin
      drive(); #1;
      check("single_hold_ready", 32'(ifa.o_ready), 32'h0);
      tick("single_hold");
    end
    drive(); #1;
    check("single_regrant", 32'(ifa.o_ready), 32'h4);
    idle(3);

    // Back-to-back round robin with no hold window.
    v[1] = 4'b1111;
    apply_reset("rr_rst");
    v[1] = 4'b1111; dat[1] = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      tick("b2b");
      check("b2b_q", 32'(ifb.o_q), 32'(8'h10 + (i % 4)));
      check("b2b_qv", 32'(ifb.o_q_valid), 32'h1);
    end

    // Wrap-around search.
    v[1] = 4'b1000; tick("wrap_g3");
    v[1] = 4'b1001; drive(); #1;
    check("wrap_first0", 32'(ifb.o_ready), 32'h1);
    tick("wrap_g0");
    drive(); #1;
    check("wrap_then3", 32'(ifb.o_ready), 32'h8);
    tick("wrap_g3b");
    v[1] = 4'b0010; tick("wrap_g1");
    v[1] = 4'b0011; drive(); #1;
    check("wrap_ptr2_grant0", 32'(ifb.o_ready), 32'h1);
    tick("wrap_g0b");
    idle(1);

    // Clear in the first hold cycle after loading 0xFF from requester 1.
    v[0] = 4'b0010; dat[0] = 32'h0000_FF00;
    tick("clr_load");
    v[0] = 4'b0000; clr[0] = 1'b1;
    tick("clr_hold");
    check("clr_q", 32'(ifa.o_q), 32'h0);
    check("clr_busy", 32'(ifa.o_busy), 32'h0);
    check("clr_owner", 32'(ifa.o_owner), 32'h1);
    clr[0] = 1'b0; v[0] = 4'b1111;
    drive(); #1;
    check("clr_next_from2", 32'(ifa.o_ready), 32'h4);
    tick("clr_next");
    idle(3);

    // Clear in IDLE blocks the grant for that cycle only.
    v[0] = 4'b0001; clr[0] = 1'b1; dat[0] = 32'h0000_0077;
    drive(); #1;
    check("clr_idle_ready", 32'(ifa.o_ready), 32'h0);
    tick("clr_idle");
    check("clr_idle_noload", 32'(ifa.o_q_valid), 32'h0);
    clr[0] = 1'b0;
    tick("clr_idle_after");
    check("clr_idle_after_q", 32'(ifa.o_q), 32'h77);

    // Randomized traffic on both instances, including one reset mid-run.
    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < 2; d++) begin
        v[d]   = 4'($urandom);
        dat[d] = $urandom;
        clr[d] = ($urandom_range(0, 7) == 0);
      end
      if (n == 150) apply_reset("rand_rst");
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit registered datapath (clocked load register, o_q output) between N_REQ requesters.
- Grants one requester per load and captures its data into the shared register.
- Holds the register stable for a programmable settle window before the next grant.
- Sits between several producer blocks and a single downstream consumer of the registered value.

Parameters:
- WIDTH, 8, data width of each requester and of the shared register.
- N_REQ, 4, number of requesters (>=1).
- HOLD_CYCLES, 2, cycles the register is held after each load before a new grant (>=0).
- Derived (local) IDW = max(1, clog2(N_REQ)), owner id width.

Ports:
- i_clk  input  1  single clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  N_REQ  per-requester request; bit k belongs to requester k.
- i_data  input  N_REQ*WIDTH  requester k data at [k*WIDTH +: WIDTH].
- i_clear  input  1  synchronous clear of the shared register and sequencer.
- o_ready  output  N_REQ  grant, one-hot or zero; transfer on i_valid[k] && o_ready[k].
- o_q  output  WIDTH  shared register value.
- o_q_valid  output  1  one-cycle pulse: o_q was loaded at the last edge.
- o_owner  output  IDW  id of the requester whose data is in o_q.
- o_busy  output  1  high while in HOLD.

Behaviour:
Reset:
- i_rst_n low forces, without a clock: o_q=0, o_q_valid=0, o_owner=0, o_busy=0, state=IDLE, hold counter=0, rr pointer=0.
- o_ready is 0 while reset is asserted.
- Reset mid-HOLD or mid-transfer aborts immediately; no load occurs.

States:
- IDLE: o_ready = one-hot of the first set i_valid bit, searching from the rr pointer upward with wrap.
  - o_ready=0 if no valid, or if i_clear=1.
  - o_ready is combinational from state, pointer, i_valid and i_clear.
- HOLD: o_ready=0, o_busy=1.
  - Counter decrements each cycle.
  - Return to IDLE on the edge where counter==1; HOLD lasts exactly HOLD_CYCLES cycles.

Transfer (requester k, cycle T):
- At the edge ending T: o_q<=i_data[k], o_owner<=k, o_q_valid<=1, pointer<=(k+1) mod N_REQ.
- If HOLD_CYCLES>0: enter HOLD with counter=HOLD_CYCLES. Otherwise stay in IDLE.
- o_q_valid is high only in cycle T+1.
- Next possible grant is in cycle T+1+HOLD_CYCLES. With HOLD_CYCLES=0, back-to-back grants occur every cycle.

Fairness:
- A requester held continuously valid is granted within N_REQ grants.
- Lowering i_valid before a grant is legal and has no side effect.

i_clear (any state):
- Next edge: o_q=0, o_q_valid=0, state=IDLE, counter=0.
- Pointer and o_owner are unchanged.
- No transfer in a cycle with i_clear=1.

Other rules:
- i_valid and i_data are sampled only on the grant cycle.
- N_REQ=1: pointer is constant 0 and o_owner is always 0.
- Unused (invalid) requesters never receive o_ready.

Test Plan:
1. Reset: assert i_rst_n=0 during HOLD with o_q=8'h3C -> o_q, o_owner, o_busy, o_q_valid and o_ready all 0 immediately, before the next edge. After release, the first grant goes to requester 0 when i_valid=4'b1111.
2. Single request (WIDTH=8, N_REQ=4, HOLD_CYCLES=2): i_valid=4'b0100, data[2]=8'hA5 at T -> o_ready=4'b0100 at T. At T+1: o_q=8'hA5, o_owner=2, o_q_valid=1. o_busy=1 in T+1..T+2. o_ready=4'b0100 again at T+3.
3. HOLD_CYCLES=0, i_valid=4'b1111 held, data k = 8'h10+k -> grants 0,1,2,3,0 on consecutive cycles. o_q sequence 10,11,12,13,10. o_q_valid continuously high.
4. Wrap: after a grant to requester 3, i_valid=4'b1001 -> grant 0 first, then 3. After a grant to 1, i_valid=4'b0011 -> grant 1 is skipped in favour of 0 only if the pointer says so; with pointer=2, the search wraps and grants 0.
5. i_clear=1 in the first HOLD cycle after loading 8'hFF from requester 1 -> next cycle o_q=0, o_busy=0, state IDLE, o_owner=1. The next grant starts search at requester 2.
6. i_clear=1 with i_valid=4'b0001 in IDLE -> o_ready=0 that cycle, no load. Grant occurs in the next cycle once i_clear=0.
